// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the IFU and decode.
// Buffers {instr, pc, pc4} entries in a circular buffer and presents them in order
// with a valid/ready handshake. in_ready drives the IFU pc_en, so a full queue stalls fetch.
// Optional feature: define FETCH_QUEUE_BYPASS_EN for zero-latency pass-through when empty.
module fetch_queue #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_instr,
    input  logic [DW-1:0] in_pc,
    input  logic [DW-1:0] in_pc4,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_instr,
    output logic [DW-1:0] out_pc,
    output logic [DW-1:0] out_pc4,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    logic [DW-1:0] instr_q [DEPTH];
    logic [DW-1:0] pc_q    [DEPTH];
    logic [DW-1:0] pc4_q   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic fifo_valid;
    logic push;
    logic pop;

    assign fifo_valid = (count_q != '0);
    // Deliberately independent of a same-cycle pop to keep pc_en off the decode path.
    assign in_ready   = (count_q != CountFull);
    assign count      = count_q;
    assign pop        = fifo_valid && out_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass = !fifo_valid && in_valid && !flush;

    // Head is the stored entry, or the incoming word when the queue is empty.
    always_comb begin
        out_valid = fifo_valid || bypass;
        out_instr = instr_q[rd_ptr_q];
        out_pc    = pc_q[rd_ptr_q];
        out_pc4   = pc4_q[rd_ptr_q];
        if (bypass) begin
            out_instr = in_instr;
            out_pc    = in_pc;
            out_pc4   = in_pc4;
        end
    end

    // A bypassed word taken by decode in the same cycle is never stored.
    assign push = in_valid && in_ready && !flush && !(bypass && out_ready);
`else
    // Head is always the stored entry at rd_ptr.
    always_comb begin
        out_valid = fifo_valid;
        out_instr = instr_q[rd_ptr_q];
        out_pc    = pc_q[rd_ptr_q];
        out_pc4   = pc4_q[rd_ptr_q];
    end

    assign push = in_valid && in_ready && !flush;
`endif

    // Pointer and occupancy next state; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset zeroes it, flush leaves contents untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                pc4_q[i]   <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= in_instr;
            pc_q[wr_ptr_q]    <= in_pc;
            pc4_q[wr_ptr_q]   <= in_pc4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, DW=32).
module tb_fetch_queue;

    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_instr;
    logic [DW-1:0] in_pc;
    logic [DW-1:0] in_pc4;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_instr;
    logic [DW-1:0] out_pc;
    logic [DW-1:0] out_pc4;
    logic          out_ready;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;

    fetch_queue #(
        .DW   (DW),
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .in_pc4   (in_pc4),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .out_pc4  (out_pc4),
        .out_ready(out_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] instr);
        in_valid = v;
        in_pc    = pc;
        in_pc4   = pc + 32'd4;
        in_instr = instr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0abc, 32'hdead_beef);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        checks++; if (out_pc4 !== 32'h0) begin failures++; $display("FAIL reset_out_pc4 got=%h exp=0", out_pc4); end
    endtask

    task automatic test_fill_stall();
        logic [DW-1:0] tab [4];
        tab[0] = 32'h0000_0013; tab[1] = 32'h0010_0093;
        tab[2] = 32'h0020_0113; tab[3] = 32'h0030_0193;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), tab[i]);
            tick();
        end
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        // Fifth word is ignored while full.
        drive(1'b1, 32'h10, 32'hdead_0001);
        tick();
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_fifth_count got=%0d exp=4", count); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL fill_head_pc got=%h exp=0", out_pc); end
        // Drain; word offered during the first pop is still ignored (in_ready was 0).
        out_ready = 1'b1;
        drive(1'b1, 32'h50, 32'hdead_0002);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_pc4 !== 32'(4 * i + 4)) begin failures++; $display("FAIL drain_pc4[%0d] got=%h exp=%h", i, out_pc4, 32'(4 * i + 4)); end
            checks++; if (out_instr !== tab[i]) begin failures++; $display("FAIL drain_instr[%0d] got=%h exp=%h", i, out_instr, tab[i]); end
            tick();
            if (i == 0) begin
                checks++; if (count !== 3'd3) begin failures++; $display("FAIL bubble_count got=%0d exp=3", count); end
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_in_ready got=%b exp=1", in_ready); end
                drive(1'b0, 32'h0, 32'h0);
            end
        end
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h208 + 32'(4 * k), 32'h1002 + 32'(k));
            #1;
            checks++; if (out_pc !== 32'h200 + 32'(4 * k)) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", k, out_pc, 32'h200 + 32'(4 * k)); end
            checks++; if (out_instr !== 32'h1000 + 32'(k)) begin failures++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", k, out_instr, 32'h1000 + 32'(k)); end
            checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=2", k, count); end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        for (int k = 6; k < 8; k++) begin
            #1;
            checks++; if (out_pc !== 32'h200 + 32'(4 * k)) begin failures++; $display("FAIL b2b_tail_pc[%0d] got=%h exp=%h", k, out_pc, 32'h200 + 32'(4 * k)); end
            tick();
        end
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL b2b_end_count got=%0d exp=0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 32'h2000 + 32'(i));
            tick();
        end
        #1;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h20, 32'h2222_2222);
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        drive(1'b1, 32'h100, 32'h3333_3333);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_next_valid got=%b exp=1", out_valid); end
        checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL flush_next_pc got=%h exp=100", out_pc); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL flush_next_count got=%0d exp=1", count); end
        // Flush while full and pushing.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 32'h4000 + 32'(i));
            tick();
        end
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL flush_full_pre got=%0d exp=4", count); end
        flush = 1'b1;
        drive(1'b1, 32'h500, 32'h5000);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_full_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_full_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_empty_push();
        out_ready = 1'b1;
        drive(1'b1, 32'h40, 32'h6000_0013);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL empty_bypass_valid got=%b exp=1", out_valid); end
        checks++; if (out_pc !== 32'h40) begin failures++; $display("FAIL empty_bypass_pc got=%h exp=40", out_pc); end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_bypass_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_bypass_after got=%b exp=0", out_valid); end
`else
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_same_valid got=%b exp=0", out_valid); end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL empty_next_valid got=%b exp=1", out_valid); end
        checks++; if (out_pc !== 32'h40) begin failures++; $display("FAIL empty_next_pc got=%h exp=40", out_pc); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL empty_next_count got=%0d exp=1", count); end
        tick();
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_end_count got=%0d exp=0", count); end
`endif
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h600 + 32'(4 * i), 32'h7000 + 32'(i));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=2", count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL rstmid_out_instr got=%h exp=0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rstmid_out_pc got=%h exp=0", out_pc); end
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_back_to_back();
        test_flush();
        test_empty_push();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the IFU and the decode stage of the pipelined CPU. It captures each fetched instruction word together with its PC and PC+4, and buffers up to DEPTH entries. It presents them in order to decode with a valid/ready handshake. Its in_ready output drives the IFU's pc_en, so a full queue stalls fetch. A taken jump or branch flushes the queue in one cycle.

## Interface
- DW, 32, width of instruction and PC fields (matches `datawidth)
- DEPTH, 4, number of entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, width of count
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  taken jump/branch; discards all entries and this cycle's input
- in_valid  in  1  IFU presents a fetched instruction this cycle
- in_instr  in  DW  instruction word from instruction memory
- in_pc  in  DW  PC of in_instr (IFU PC_now)
- in_pc4  in  DW  PC+4 (IFU PC_add_4)
- in_ready  out  1  queue can accept; connects to IFU pc_en
- out_valid  out  1  head entry valid for decode
- out_instr  out  DW  head instruction word
- out_pc  out  DW  head PC
- out_pc4  out  DW  head PC+4
- out_ready  in  1  decode accepts head (not stalled)
- count  out  CW  number of stored entries, 0..DEPTH

## Operation
- Storage: DEPTH-entry circular buffer of {instr, pc, pc4}, with wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and count.
- in_ready = (count != DEPTH). It does not depend on a same-cycle pop.
- Push when in_valid && in_ready && !flush: write at wr_ptr, then increment wr_ptr.
- Pop when out_valid && out_ready && !flush: increment rd_ptr.
- count next value:
  - push and no pop: +1
  - pop and no push: −1
  - both or neither: unchanged
- Output fields: out_valid = (count != 0). out_* is a combinational read of entry rd_ptr.
- Flush, taking priority over everything:
  - wr_ptr, rd_ptr and count become 0.
  - in_valid that cycle is dropped; out_ready that cycle is ignored.
  - Entry contents are not cleared.
- Reset behaves as flush. In addition, all entries are cleared to 0.
- in_valid when in_ready=0: the word is ignored. The IFU must hold its PC because pc_en=0.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, out_instr/out_pc/out_pc4=0.
- Latency without bypass: a word pushed at edge N appears with out_valid=1 after edge N, i.e. in cycle N+1.
- Throughput: 1 push and 1 pop per cycle.
- Full: count=DEPTH and in_ready=0. A pop in that cycle raises in_ready the next cycle (one bubble on the IFU side).
- Empty: out_valid=0 and out_ready is ignored. A simultaneous push with no pop results in count=1.
- Pointer wrap: from DEPTH−1 to 0, with no loss of ordering.
- Flush while full or while pushing: count is 0 after the edge, in_ready=1 and out_valid=0 in the next cycle.
- Reset asserted mid-stream: same as flush, plus entries are zeroed; it takes effect at the edge where rst=1.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count=0, in_valid=1 and flush=0, the input passes through combinationally: out_valid=1 and out_*=in_* in the same cycle.
  - If out_ready=1 in that cycle, the word is consumed and not written, so count stays 0.
  - If out_ready=0, the word is written normally.
  - Zero-cycle latency when empty.
- Undefined: no combinational path from in_* to out_*. Latency is always 1 cycle, as specified above.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 → after release, count=0, out_valid=0, in_ready=1, out_instr=0.
- Fill and stall:
  - Stimulus: push instr 0x00000013/0x00100093/0x00200113/0x00300193 with pc 0x0/4/8/C, out_ready=0.
  - Response: count=4 and in_ready=0. A fifth in_valid is ignored.
  - Then out_ready=1 drains in order; out_pc4 reads 0x4, 0x8, 0xC, 0x10.
- Simultaneous push/pop at count=2 for 6 cycles → count stays 2, pointers wrap past 3→0, and output order is preserved.
- Flush with count=3 and in_valid=1 (pc 0x20) → next cycle count=0 and out_valid=0. Pushing pc 0x100 afterward yields out_pc=0x100 first.
- Empty push:
  - Stimulus: in_valid=1, pc 0x40, out_ready=1.
  - Without FETCH_QUEUE_BYPASS_EN: out_valid=0 this cycle, out_pc=0x40 next cycle.
  - With FETCH_QUEUE_BYPASS_EN: out_pc=0x40 the same cycle and count remains 0.
- Mid-stream reset: rst=1 at count=2 → after the edge count=0, out_valid=0, out_instr=0.
